// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: resolves forwarded operands at capture and buffers up to
// two instructions (main + skid) so the registered in_ready never stalls throughput.
module id_ex_stage #(
    parameter int WIDTH = 8,
    parameter int OPW   = 4,
    parameter int RAW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_op,
    input  logic [RAW-1:0]   in_rs,
    input  logic [RAW-1:0]   in_rt,
    input  logic [RAW-1:0]   in_rd,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic [WIDTH-1:0] in_imm,
    input  logic             in_use_imm,
    input  logic             fwd_ex_valid,
    input  logic [RAW-1:0]   fwd_ex_rd,
    input  logic [WIDTH-1:0] fwd_ex_data,
    input  logic             fwd_wb_valid,
    input  logic [RAW-1:0]   fwd_wb_rd,
    input  logic [WIDTH-1:0] fwd_wb_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OPW-1:0]   out_op,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [RAW-1:0]   out_rd
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } state_t;

    typedef struct packed {
        logic [OPW-1:0]   op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [RAW-1:0]   rd;
    } entry_t;

    state_t state, state_next;
    entry_t main_q, main_next;
    entry_t skid_q, skid_next;
    entry_t incoming;
    logic [WIDTH-1:0] op_a, op_b;
    logic in_xfer, out_xfer;

    // Register 0 is hardwired zero; a nonzero source match implies a nonzero bypass rd.
    always_comb begin
        op_a = rs_data;
        if (in_rs == '0)
            op_a = '0;
        else if (fwd_ex_valid && fwd_ex_rd == in_rs)
            op_a = fwd_ex_data;
        else if (fwd_wb_valid && fwd_wb_rd == in_rs)
            op_a = fwd_wb_data;

        op_b = rt_data;
        if (in_use_imm)
            op_b = in_imm;
        else if (in_rt == '0)
            op_b = '0;
        else if (fwd_ex_valid && fwd_ex_rd == in_rt)
            op_b = fwd_ex_data;
        else if (fwd_wb_valid && fwd_wb_rd == in_rt)
            op_b = fwd_wb_data;
    end

    assign incoming = '{op: in_op, a: op_a, b: op_b, rd: in_rd};
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        state_next = state;
        main_next  = main_q;
        skid_next  = skid_q;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        main_next  = incoming;
                        state_next = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_next = incoming;
                    end else if (in_xfer) begin
                        skid_next  = incoming;
                        state_next = FULL;
                    end else if (out_xfer) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        main_next  = skid_q;
                        state_next = ONE;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state  <= state_next;
            main_q <= main_next;
            skid_q <= skid_next;
        end
    end

    // Handshake flags decode straight from the state register, so both are registered.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_op    = main_q.op;
    assign out_a     = main_q.a;
    assign out_b     = main_q.b;
    assign out_rd    = main_q.rd;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter WIDTH, 8, operand/result data width (signed two's complement).
REQ-002 Parameter OPW, 4, ALU opcode width.
REQ-003 Parameter RAW, 3, register address width (8 registers).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  decode offers an instruction this cycle.
REQ-007 in_ready  output  1  stage can accept; registered, equals "skid entry empty".
REQ-008 in_op  input  OPW  ALU opcode.
REQ-009 in_rs, in_rt, in_rd  input  RAW each  source A, source B, destination register.
REQ-010 rs_data, rt_data  input  WIDTH each  register-file read data for in_rs, in_rt.
REQ-011 in_imm  input  WIDTH  immediate; in_use_imm  input  1  selects in_imm as B.
REQ-012 fwd_ex_valid, fwd_ex_rd, fwd_ex_data  input  1/RAW/WIDTH  ALU-output bypass.
REQ-013 fwd_wb_valid, fwd_wb_rd, fwd_wb_data  input  1/RAW/WIDTH  writeback bypass.
REQ-014 flush  input  1  discard all held entries.
REQ-015 out_valid  output  1  ALU operands valid; out_ready  input  1  ALU accepts.
REQ-016 out_op, out_a, out_b, out_rd  output  OPW/WIDTH/WIDTH/RAW  registered ALU-facing fields.

Function
REQ-017 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
REQ-018 Operand A resolution at capture: in_rs==0 -> 0; else fwd_ex match (valid, rd==rs, rd!=0) -> fwd_ex_data; else fwd_wb match -> fwd_wb_data; else rs_data.
REQ-019 Operand B: in_use_imm -> in_imm; else same priority chain as REQ-018 applied to in_rt/rt_data.
REQ-020 Forwarding evaluated only at capture; held entries never re-resolved.
REQ-021 Storage: main entry (drives out_*) plus one skid entry; FSM states EMPTY, ONE, FULL.
REQ-022 EMPTY: in transfer -> capture into main, go ONE.
REQ-023 ONE, in only -> if out transfer same cycle, main reloads with new entry, stay ONE; else new entry into skid, go FULL.
REQ-024 ONE, out only -> go EMPTY; no in, no out -> hold.
REQ-025 FULL: in_ready=0; out transfer -> skid moves to main, go ONE; else hold.
REQ-026 out_valid=1 in ONE and FULL only; out_* fields stable while out_valid & ~out_ready.
REQ-027 Throughput one instruction/cycle when out_ready held high; latency one cycle in->out_valid.
REQ-028 flush has priority over all transfers: next state EMPTY, in-flight in transfer dropped, in_ready=1 next cycle.
REQ-029 Entry ordering strictly FIFO; no entry lost or duplicated across any state/event combination.
REQ-030 No arithmetic performed; data passes bit-exact, no width change.

Reset
REQ-031 rst asserted -> immediately state EMPTY, out_valid=0, in_ready=1, out_op=0, out_a=0, out_b=0, out_rd=0, skid cleared.
REQ-032 rst deasserted -> first capture allowed on the following rising edge; rst mid-transfer discards all entries.

Verification
REQ-033 Reset, then in_op=0, rs=1 (rs_data=21), rt=2 (rt_data=3), rd=3, out_ready=1 -> next cycle out_valid=1, out_a=21, out_b=3, out_rd=3.
REQ-034 rs=4, fwd_ex (rd=4, data=9) and fwd_wb (rd=4, data=7) both valid, rs_data=1 -> out_a=9; ex invalid -> out_a=7; rs=0 with matches -> out_a=0.
REQ-035 in_use_imm=1, in_imm=-4, rt matched by fwd_ex -> out_b=-4 (8'hFC).
REQ-036 out_ready=0, three back-to-back offers A,B,C -> A on out, B in skid, in_ready=0, C held; out_ready=1 -> A,B,C emitted in order, one per cycle.
REQ-037 FULL state, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, no entry later emitted.
REQ-038 Async rst pulse between clock edges while FULL -> outputs zero and in_ready=1 before next rising edge.
